elevator_request_scheduler: RTL

- Upstream stage of elevator_controller.
- Latches floor-call button presses into a pending set and chooses the next target floor with a direction-preserving sweep (SCAN) policy.
- Presents the target to the controller as request_floor and holds it until the controller reports complete at that floor.
- Clears the served call and repeats; detects a stalled controller with a watchdog.

---
 rtl/elevator_request_scheduler_if.sv | 26 ++
 rtl/elevator_request_scheduler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/elevator_request_scheduler_if.sv
// Bundle between the floor-call scheduler and its neighbours: button/sensor
// inputs, the held target request to the controller, and status flags.
interface elevator_request_scheduler_if #(
   parameter int FLOORS  = 8,
   parameter int FLOOR_W = 3
);
   logic [FLOORS-1:0]  call_buttons;
   logic [FLOOR_W-1:0] current_floor;
   logic               complete;
   logic [FLOOR_W-1:0] request_floor;
   logic               request_valid;
   logic [FLOORS-1:0]  pending;
   logic               served;
   logic               sweep_up;
   logic               fault;

   modport master (
      input  call_buttons, current_floor, complete,
      output request_floor, request_valid, pending, served, sweep_up, fault
   );

   modport slave (
      output call_buttons, current_floor, complete,
      input  request_floor, request_valid, pending, served, sweep_up, fault
   );
endinterface

// File: rtl/elevator_request_scheduler.sv
// Latches floor calls and issues one target at a time to the elevator
// controller using a direction-preserving sweep, with a stall watchdog.
module elevator_request_scheduler #(
   parameter int FLOORS   = 8,
   parameter int FLOOR_W  = 3,
   parameter int MAX_WAIT = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   elevator_request_scheduler_if.master bus
);

   localparam int CNT_W = $clog2(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, SELECT, WAIT, CLEAR} state_t;

   state_t             state, state_next;
   logic [FLOORS-1:0]  pending_q, clear_mask;
   logic [FLOOR_W-1:0] request_floor_q, target;
   logic               sweep_up_q, sweep_next;
   logic               fault_q, fault_next;
   logic [CNT_W-1:0]   wd_cnt, wd_cnt_next;
   logic               request_valid, served;

   logic               here_hit, found_above, found_below;
   logic [FLOOR_W-1:0] lowest_above, highest_below;

   // Nearest pending floor on each side of the car, plus a hit at the car.
   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      here_hit      = 1'b0;
      found_above   = 1'b0;
      found_below   = 1'b0;
      lowest_above  = '0;
      highest_below = '0;
      for (int f = 0; f < FLOORS; f++) begin
         if (pending_q[f]) begin
            if (f == int'(bus.current_floor)) begin
               here_hit = 1'b1;
            end else if (f > int'(bus.current_floor)) begin
               if (!found_above) begin
                  found_above  = 1'b1;
                  lowest_above = FLOOR_W'(f);
               end
            end else begin
               found_below   = 1'b1;
               highest_below = FLOOR_W'(f);
            end
         end
      end
   end

   // SCAN choice: keep going in the current direction, reverse only when
   // nothing remains ahead.
   always_comb begin
      target     = request_floor_q;
      sweep_next = sweep_up_q;
      if (here_hit) begin
         target = bus.current_floor;
      end else if (sweep_up_q && found_above) begin
         target = lowest_above;
      end else if (sweep_up_q) begin
         target     = highest_below;
         sweep_next = 1'b0;
      end else if (found_below) begin
         target = highest_below;
      end else begin
         target     = lowest_above;
         sweep_next = 1'b1;
      end
   end

   always_comb begin
      state_next    = state;
      wd_cnt_next   = wd_cnt;
      fault_next    = fault_q;
      clear_mask    = '0;
      request_valid = 1'b0;
      served        = 1'b0;
      case (state)
         IDLE: begin
            if (|pending_q) state_next = SELECT;
         end
         SELECT: begin
            wd_cnt_next = '0;
            state_next  = WAIT;
         end
         WAIT: begin
            request_valid = 1'b1;
            if (bus.complete && (bus.current_floor == request_floor_q)) begin
               state_next = CLEAR;
            end else if (wd_cnt == CNT_W'(MAX_WAIT - 1)) begin
               // Target bit is left pending so the call is retried.
               fault_next = 1'b1;
               state_next = IDLE;
            end else begin
               wd_cnt_next = wd_cnt + 1'b1;
            end
         end
         CLEAR: begin
            served     = 1'b1;
            clear_mask = {{(FLOORS-1){1'b0}}, 1'b1} << request_floor_q;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         pending_q       <= '0;
         request_floor_q <= '0;
         sweep_up_q      <= 1'b1;
         fault_q         <= 1'b0;
         wd_cnt          <= '0;
      end else begin
         state     <= state_next;
         pending_q <= (pending_q | bus.call_buttons) & ~clear_mask;
         wd_cnt    <= wd_cnt_next;
         fault_q   <= fault_next;
         if (state == SELECT) begin
            request_floor_q <= target;
            sweep_up_q      <= sweep_next;
         end
      end
   end

   assign bus.request_floor = request_floor_q;
   assign bus.request_valid = request_valid;
   assign bus.pending       = pending_q;
   assign bus.served        = served;
   assign bus.sweep_up      = sweep_up_q;
   assign bus.fault         = fault_q;

endmodule
